// File: rtl/paddle_move_controller_pkg.sv
// Shared game definitions: paddle state/direction enums, screen and paddle
// geometry defaults, and the datapath widths used by the motion controller.
package paddle_move_controller_pkg;

    // Geometry shared with the collision and bitmap blocks
    localparam int unsigned SCREEN_WIDTH_PX = 640;
    localparam int unsigned PADDLE_WIDTH_PX = 64;
    localparam int unsigned PADDLE_Y_PX     = 448;
    localparam int unsigned PADDLE_INIT_X   = 288;

    // Datapath widths
    localparam int unsigned COORD_W = 11;
    localparam int unsigned POS_W   = 12;
    localparam int unsigned SPEED_W = 4;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        FROZEN = 2'd2
    } paddle_state_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } paddle_dir_t;

endpackage

// File: rtl/paddle_move_controller.sv
// Frame-rate paddle motion controller: accelerates the paddle while a key is
// held, caps the speed, clamps at the screen edges and sequences the
// IDLE / MOVE / FROZEN phases.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   startOfFrame      - one-cycle pulse per video frame
//   leftKey, rightKey - key levels, sampled only at start of frame
//   freezeHit         - one-cycle stun pulse (ignored while idle)
//   levelRestart      - one-cycle pulse, recentre and go idle
//   topLeftX/Y        - paddle top-left position
//   speed             - current speed magnitude
//   frozen            - high while stunned
module paddle_move_controller
    import paddle_move_controller_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = SCREEN_WIDTH_PX,
    parameter int unsigned PADDLE_WIDTH  = PADDLE_WIDTH_PX,
    parameter int unsigned PADDLE_Y      = PADDLE_Y_PX,
    parameter int unsigned INIT_X        = PADDLE_INIT_X,
    parameter int unsigned ACCEL         = 1,
    parameter int unsigned MAX_SPEED     = 8,
    parameter int unsigned FREEZE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               leftKey,
    input  logic               rightKey,
    input  logic               freezeHit,
    input  logic               levelRestart,
    output logic [COORD_W-1:0] topLeftX,
    output logic [COORD_W-1:0] topLeftY,
    output logic [SPEED_W-1:0] speed,
    output logic               frozen
);

    localparam int unsigned X_MAX = SCREEN_WIDTH - PADDLE_WIDTH;

    paddle_state_t      state_q, state_d;
    paddle_dir_t        last_dir_q, last_dir_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frozen_q, frozen_d;

    logic               dir_valid_c;
    paddle_dir_t        dir_c;
    logic               freeze_c;
    logic [SPEED_W:0]   spd_sum_c;
    logic [SPEED_W-1:0] spd_new_c;
    logic signed [POS_W-1:0] pos_c;

    // Key decode: both keys held counts as no direction
    assign dir_valid_c = leftKey ^ rightKey;
    assign dir_c       = (leftKey && !rightKey) ? LEFT : RIGHT;
    assign freeze_c    = freezeHit && (state_q != IDLE);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_dir_q <= RIGHT;
            x_q        <= COORD_W'(INIT_X);
            speed_q    <= '0;
            cnt_q      <= '0;
            frozen_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            x_q        <= x_d;
            speed_q    <= speed_d;
            cnt_q      <= cnt_d;
            frozen_q   <= frozen_d;
        end
    end

    // Next-state and freeze counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (levelRestart) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (freeze_c) begin
            state_d = FROZEN;
            cnt_d   = CNT_W'(FREEZE_FRAMES);
        end else if (startOfFrame) begin
            case (state_q)
                IDLE:    if (dir_valid_c) state_d = MOVE;
                FROZEN: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = MOVE;
                end
                default: ;
            endcase
        end
    end

    // Next values of the registered outputs: speed, position, frozen flag
    always_comb begin
        x_d        = x_q;
        speed_d    = speed_q;
        last_dir_d = last_dir_q;
        frozen_d   = (state_d == FROZEN);
        spd_sum_c  = {1'b0, speed_q} + (SPEED_W+1)'(ACCEL);
        spd_new_c  = '0;
        pos_c      = $signed({1'b0, x_q});

        if (dir_valid_c) begin
            if (dir_c != last_dir_q)
                spd_new_c = SPEED_W'(ACCEL);
            else if (spd_sum_c > (SPEED_W+1)'(MAX_SPEED))
                spd_new_c = SPEED_W'(MAX_SPEED);
            else
                spd_new_c = spd_sum_c[SPEED_W-1:0];
        end

        if (dir_valid_c && dir_c == LEFT)
            pos_c = $signed({1'b0, x_q}) - $signed({{(POS_W-SPEED_W){1'b0}}, spd_new_c});
        else
            pos_c = $signed({1'b0, x_q}) + $signed({{(POS_W-SPEED_W){1'b0}}, spd_new_c});

        if (levelRestart) begin
            x_d     = COORD_W'(INIT_X);
            speed_d = '0;
        end else if (freeze_c) begin
            speed_d = '0;
        end else if (startOfFrame) begin
            case (state_q)
                IDLE: if (dir_valid_c) last_dir_d = dir_c;
                MOVE: begin
                    if (dir_valid_c) last_dir_d = dir_c;
                    // Hitting either edge pins the paddle and kills its speed
                    if (pos_c[POS_W-1]) begin
                        x_d     = '0;
                        speed_d = '0;
                    end else if (pos_c > $signed(POS_W'(X_MAX))) begin
                        x_d     = COORD_W'(X_MAX);
                        speed_d = '0;
                    end else begin
                        x_d     = pos_c[COORD_W-1:0];
                        speed_d = spd_new_c;
                    end
                end
                default: speed_d = '0;
            endcase
        end
    end

    // Output drive
    assign topLeftX = x_q;
    assign topLeftY = COORD_W'(PADDLE_Y);
    assign speed    = speed_q;
    assign frozen   = frozen_q;

endmodule

// File: tb/tb_paddle_move_controller.sv
// Self-checking bench for paddle_move_controller: behavioural model of the
// paddle motion rules, per-cycle comparison, directed scenarios with literal
// expectations, then randomized frames, keys, stuns, restarts and resets.
module tb_paddle_move_controller;

    localparam int INIT_X = 288;
    localparam int X_MAX  = 640 - 64;
    localparam int PY     = 448;
    localparam int ACC    = 1;
    localparam int MAXS   = 8;
    localparam int FF     = 3;

    localparam int PH_IDLE   = 0;
    localparam int PH_MOVE   = 1;
    localparam int PH_FROZEN = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        leftKey = 1'b0;
    logic        rightKey = 1'b0;
    logic        freezeHit = 1'b0;
    logic        levelRestart = 1'b0;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic [3:0]  speed;
    logic        frozen;

    paddle_move_controller #(.FREEZE_FRAMES(FF)) dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .leftKey      (leftKey),
        .rightKey     (rightKey),
        .freezeHit    (freezeHit),
        .levelRestart (levelRestart),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .speed        (speed),
        .frozen       (frozen)
    );

    always #5 clk = ~clk;

    // Model state: position, speed, phase, SOFs still to ignore, heading (-1/+1)
    int mx = INIT_X, ms = 0, mph = PH_IDLE, mleft = 0, mlast = 1;
    int n_vec = 0, n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_apply(input bit rst, input bit sof, input bit l,
                               input bit r, input bit fh, input bit lr);
        int d, p;
        d = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
        if (rst) begin
            mx = INIT_X; ms = 0; mph = PH_IDLE; mleft = 0; mlast = 1;
        end else if (lr) begin
            mx = INIT_X; ms = 0; mph = PH_IDLE; mleft = 0;
        end else if (fh && mph != PH_IDLE) begin
            mph = PH_FROZEN; mleft = FF; ms = 0;
        end else if (sof) begin
            if (mph == PH_IDLE) begin
                if (d != 0) begin mph = PH_MOVE; mlast = d; end
            end else if (mph == PH_FROZEN) begin
                mleft--;
                if (mleft == 0) mph = PH_MOVE;
            end else begin
                if (d == 0)          ms = 0;
                else if (d == mlast) ms = (ms + ACC > MAXS) ? MAXS : ms + ACC;
                else                 ms = ACC;
                if (d != 0) mlast = d;
                p = mx + d * ms;
                if (p < 0)          begin mx = 0;     ms = 0; end
                else if (p > X_MAX) begin mx = X_MAX; ms = 0; end
                else                mx = p;
            end
        end
    endtask

    task automatic step(input bit rst, input bit sof, input bit l,
                        input bit r, input bit fh, input bit lr);
        reset = rst; startOfFrame = sof; leftKey = l; rightKey = r;
        freezeHit = fh; levelRestart = lr;
        @(posedge clk);
        #1;
        model_apply(rst, sof, l, r, fh, lr);
        chk_en = 1'b1;
    endtask

    // One SOF followed by two quiet cycles, keys held throughout
    task automatic frame(input bit l, input bit r);
        step(0, 1, l, r, 0, 0);
        step(0, 0, l, r, 0, 0);
        step(0, 0, l, r, 0, 0);
    endtask

    task automatic pin(input string tag, input int ex, input int esp, input int efr);
        check({tag, "_x"}, int'(topLeftX), ex);
        check({tag, "_speed"}, int'(speed), esp);
        check({tag, "_frozen"}, int'(frozen), efr);
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("topLeftX", int'(topLeftX), mx);
            check("topLeftY", int'(topLeftY), PY);
            check("speed", int'(speed), ms);
            check("frozen", int'(frozen), (mph == PH_FROZEN) ? 1 : 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit l, r, sof_prev, sof;
        int guard;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0);
        pin("reset", INIT_X, 0, 0);

        // Accelerate right from idle
        frame(0, 1);
        pin("leave_idle", 288, 0, 0);
        frame(0, 1);
        pin("first_move", 289, 1, 0);
        repeat (8) frame(0, 1);
        pin("ten_sof", 332, 8, 0);

        // Run into the right edge
        guard = 0;
        while (mx != X_MAX && guard < 100) begin frame(0, 1); guard++; end
        pin("right_clamp", 576, 0, 0);
        frame(0, 1);
        pin("right_clamp_again", 576, 0, 0);

        // Reverse to left, build speed 5, then reverse and release
        repeat (5) frame(1, 0);
        pin("left_speed5", 561, 5, 0);
        frame(0, 1);
        pin("reverse", 562, 1, 0);
        frame(1, 1);
        pin("both_keys", 562, 0, 0);

        // Freeze for FF frames, then move with speed 1
        step(0, 0, 0, 1, 1, 0);
        pin("freeze_enter", 562, 0, 1);
        frame(0, 1);
        frame(0, 1);
        pin("freeze_two", 562, 0, 1);
        frame(0, 1);
        pin("freeze_exit", 562, 0, 0);
        frame(0, 1);
        pin("after_freeze", 563, 1, 0);

        // Retrigger after two frozen SOFs extends by a full period
        step(0, 0, 0, 1, 1, 0);
        frame(0, 1);
        frame(0, 1);
        step(0, 0, 0, 1, 1, 0);
        frame(0, 1);
        frame(0, 1);
        pin("retrig_hold", 563, 0, 1);
        frame(0, 1);
        pin("retrig_exit", 563, 0, 0);

        // Restart, stun and SOF coincide: restart wins
        frame(0, 1);
        step(0, 1, 0, 1, 1, 1);
        pin("restart_wins", 288, 0, 0);
        frame(0, 0);
        pin("idle_no_key", 288, 0, 0);
        frame(0, 1);
        frame(0, 1);
        pin("restart_move", 289, 1, 0);

        // Reset while frozen with two SOFs left
        step(0, 0, 0, 1, 1, 0);
        frame(0, 1);
        step(1, 0, 0, 1, 0, 0);
        pin("reset_frozen", 288, 0, 0);
        repeat (3) step(0, 0, 1, 0, 0, 0);
        pin("keys_between_sof", 288, 0, 0);
        frame(1, 0);
        pin("post_reset_idle_exit", 288, 0, 0);

        // Randomized frames, key runs and glitches, stuns, restarts, resets
        l = 1'b0; r = 1'b1; sof_prev = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39) == 0) begin
                l = 1'($urandom_range(1));
                r = 1'($urandom_range(1));
            end
            sof = !sof_prev && ($urandom_range(2) == 0);
            if (!sof && $urandom_range(7) == 0)
                step(0, 0, 1'($urandom_range(1)), 1'($urandom_range(1)), 0, 0);
            else
                step($urandom_range(999) == 0, sof, l, r,
                     $urandom_range(149) == 0, $urandom_range(399) == 0);
            sof_prev = sof;
        end

        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
